// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions used by the multiplier and its divider companion.
package dsp_pkg;

  localparam int MUL_W     = 16;
  localparam int MUL_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul16.sv
// Sequential unsigned shift-add multiplier: pout = ain*bin + cin, 17 clocks after iv.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iv
// RUN   | 16 shift-add steps, cnt counts 0..15
// DONE  | one cycle; {hi,lo} is copied to pout and ov pulses
//
// iv loads a new operation from any state, so an iv during RUN aborts the
// running operation, and an iv during DONE chains a new one while the
// finishing result is still transferred.
module mul16
  import dsp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MUL_W-1:0]       ain,
  input  logic [MUL_W-1:0]       bin,
  input  logic [MUL_W-1:0]       cin,
  input  logic                   iv,
  output logic [2*MUL_W-1:0]     pout,
  output logic                   ov,
  output logic                   busy
);

  mul_state_t           state;
  mul_state_t           state_next;
  logic [MUL_CNT_W-1:0] cnt;
  logic [MUL_W-1:0]     a;
  logic                 carry;
  logic [MUL_W-1:0]     hi;
  logic [MUL_W-1:0]     lo;
  logic [MUL_W:0]       step_sum;
  logic                 step_en;
  logic                 done_xfer;
  logic                 last_step;

  assign last_step = (cnt == MUL_CNT_W'(MUL_W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and step/transfer strobes; iv always wins and (re)loads.
  always_comb begin
    state_next = state;
    step_en    = 1'b0;
    done_xfer  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (iv) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        step_en = !iv;
        if (!iv && last_step) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_xfer  = 1'b1;
        state_next = iv ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Conditional add of the multiplicand; the 17th bit is the carry that the
  // following shift moves into hi[15], so no product bit is lost.
  always_comb begin
    step_sum = {carry, hi};
    if (lo[0]) step_sum = {1'b0, hi} + {1'b0, a};
  end

  // Working registers, result register and the ov pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      carry <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      pout  <= '0;
      ov    <= 1'b0;
    end else begin
      ov <= done_xfer;
      if (done_xfer) pout <= {hi, lo};
      if (iv) begin
        a     <= ain;
        hi    <= cin;
        lo    <= bin;
        carry <= 1'b0;
        cnt   <= '0;
      end else if (step_en) begin
        {carry, hi, lo} <= {1'b0, step_sum, lo[MUL_W-1:1]};
        cnt             <= cnt + MUL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul16.sv
// Scoreboard bench for mul16: the driver pushes a*b+c with its due cycle, a
// monitor pops and compares on every ov.
module tb_mul16;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [15:0] ain, bin, cin;
  logic [31:0] pout;
  logic        ov;
  logic        busy;

  always #5 clk = ~clk;

  mul16 dut (
    .clk  (clk),
    .rst  (rst),
    .ain  (ain),
    .bin  (bin),
    .cin  (cin),
    .iv   (iv),
    .pout (pout),
    .ov   (ov),
    .busy (busy)
  );

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   pending = 1'b0;
  int   last_drive = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every ov must match the oldest outstanding operation, on time.
  always @(negedge clk) begin
    if (ov) begin
      if (sb.size() == 0) begin
        chk("ov_unexpected", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("pout", pout, mon_e.val);
        chk("ov_latency", cyc, mon_e.due);
      end
    end
  end

  // Issue one operation from a negedge. An issue less than 17 clocks after
  // the previous one lands while that one is still running and kills it.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    exp_t e;
    if (pending && cyc < last_drive + 17) void'(sb.pop_back());
    ain = x;
    bin = y;
    cin = z;
    iv  = 1'b1;
    e.val = 32'(longint'(x) * longint'(y) + longint'(z));
    e.due = cyc + 18;
    sb.push_back(e);
    pending    = 1'b1;
    last_drive = cyc;
    @(negedge clk);
    iv  = 1'b0;
    ain = 16'($urandom);
    bin = 16'($urandom);
    cin = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc;
    int gap;
    logic [15:0] x, y, z;

    rst = 1'b1;
    iv  = 1'b0;
    ain = '0;
    bin = '0;
    cin = '0;
    repeat (3) @(negedge clk);
    chk("rst_pout", pout, 0);
    chk("rst_ov", ov, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full-scale operands, busy width.
    issue(16'hFFFF, 16'hFFFF, 16'hFFFF);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc, 17);

    issue(16'h04D2, 16'h0037, 16'h0000);
    repeat (20) @(negedge clk);
    issue(16'd142, 16'd7, 16'd6);
    repeat (20) @(negedge clk);

    // Restart five cycles in: only the second operation completes.
    issue(16'd5, 16'd5, 16'd0);
    repeat (4) @(negedge clk);
    issue(16'd2, 16'd3, 16'd1);
    repeat (25) @(negedge clk);

    // Reset in the middle of an operation.
    issue(16'h1357, 16'h2468, 16'h0042);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    pending = 1'b0;
    @(negedge clk);
    chk("midrst_pout", pout, 0);
    chk("midrst_ov", ov, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    // Reset coincident with iv: nothing starts.
    rst = 1'b1;
    iv  = 1'b1;
    ain = 16'h0003;
    bin = 16'h0004;
    cin = 16'h0005;
    @(negedge clk);
    rst = 1'b0;
    iv  = 1'b0;
    chk("rst_iv_busy", busy, 0);
    repeat (20) @(negedge clk);

    // bin=0 and a chained operation on the DONE cycle.
    issue(16'hABCD, 16'h0000, 16'h1234);
    repeat (16) @(negedge clk);
    issue(16'h8001, 16'hFFFE, 16'h7FFF);
    chk("b2b_busy", busy, 1);
    repeat (20) @(negedge clk);

    // Random operations with random spacing: aborts, chains and gaps.
    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 4))
        0:       x = 16'hFFFF;
        1:       x = 16'h0000;
        default: x = 16'($urandom);
      endcase
      y = 16'($urandom);
      z = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       gap = $urandom_range(2, 12);
        1:       gap = 16;
        default: gap = $urandom_range(16, 22);
      endcase
      issue(x, y, z);
      repeat (gap) @(negedge clk);
    end
    repeat (25) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul16.md
# mul16

Sequential unsigned 16x16 shift-add multiplier with a 16-bit addend, producing a 32-bit result `a*b + c`. It is the inverse companion of the restoring divider: feeding it quotient, divisor and remainder rebuilds the dividend. It sits beside the divider in the DSP datapath and uses the same iv/ov valid convention with the same 17-clock latency, so the two can be pipelined symmetrically.

## Interface
- `W`, 16, operand width; product width is 2*W. All text below assumes W=16.
- `clk`  in  1  master clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ain`  in  16  multiplicand (unsigned).
- `bin`  in  16  multiplier (unsigned).
- `cin`  in  16  addend (unsigned); use 0 for a plain multiply.
- `iv`  in  1  inputs valid; single-cycle strobe that loads `ain`/`bin`/`cin`.
- `pout`  out  32  result `ain*bin + cin`; held until the next completion.
- `ov`  out  1  result valid; one-cycle pulse.
- `busy`  out  1  high while an operation is in progress.

## Operation
- States:
  - IDLE: waiting for `iv`.
  - RUN: 16 steps, counter 0..15.
  - DONE: one cycle, transfers the result.
- Working registers:
  - `a` (16 bits): multiplicand.
  - `p`: 33 bits, made of the 1-bit `carry`, 16-bit `hi` and 16-bit `lo`.
- Load, on any edge where `iv`=1 and `rst`=0:
  - `a` <= `ain`, `hi` <= `cin`, `lo` <= `bin`, `carry` <= 0.
  - Counter <= 0, state <= RUN.
- RUN step, each edge:
  - If `lo[0]`, then `{carry,hi}` <= `hi + a`, formed as a 17-bit sum. Otherwise `hi` is unchanged.
  - Then `{carry,hi,lo}` shifts right by 1.
  - After step 15, go to DONE.
- DONE edge: `pout` <= `{hi,lo}`, `ov` <= 1, state <= IDLE.
- Arithmetic:
  - The maximum result is (2^16-1)^2 + (2^16-1) = 0xFFFF0000, so the result never overflows 32 bits.
  - The carry bit must be kept through every shift.
- Restart: `iv` while in RUN aborts the current operation and reloads. The aborted operation produces no `ov` and leaves `pout` unchanged.
- `iv` in the same cycle as DONE: the completing result is still written to `pout` with `ov`=1. The new operation loads on that same edge and `busy` stays high.
- Reset:
  - Clears state to IDLE, `pout` to 0, `ov` to 0 and `busy` to 0.
  - `rst` overrides `iv` in the same cycle.
  - Reset mid-operation discards the operation, and no `ov` follows.
- Reset values of all outputs: `pout`=0x00000000, `ov`=0, `busy`=0.

## Timing
- `iv` sampled at edge 0.
- Steps occur on edges 1..16.
- The DONE transfer occurs on edge 17. `ov` and the new `pout` are visible in the cycle after edge 17, i.e. 17 clocks after `iv`, matching the divider.
- `ov` lasts exactly one cycle.
- `busy` is 1 from after edge 0 until edge 17. It then falls to 0 unless a new `iv` arrived on edge 17.
- Maximum throughput: one operation per 17 clocks. `iv` must be issued only when `busy`=0 or on the DONE cycle; any earlier `iv` restarts the operation.
- Input operands need only be valid in the `iv` cycle.

## Structure
- Shared package `dsp_pkg` holds:
  - Constants `MUL_W`=16 and `MUL_CNT_W`=4.
  - Enum `mul_state_t` with values IDLE, RUN, DONE.
- Single module with no sub-module. The 17-bit add and the right shift are an inferred adder feeding the `p` register.

## Test plan
- `ain`=0xFFFF, `bin`=0xFFFF, `cin`=0xFFFF -> `pout`=0xFFFF0000, `ov`=1 exactly 17 clocks after `iv`, `busy` high for 17 cycles.
- `ain`=0x04D2, `bin`=0x0037, `cin`=0 -> `pout`=0x0001091E.
- Divider round-trip: `ain`=142, `bin`=7, `cin`=6 -> `pout`=0x000003E8 (1000).
- `iv` at cycle 0 (`ain`=5, `bin`=5, `cin`=0), then `iv` at cycle 5 (`ain`=2, `bin`=3, `cin`=1):
  - No `ov` at cycle 17.
  - A single `ov` at cycle 22 with `pout`=0x00000007.
- `rst` at cycle 8 of an operation -> `pout`=0, `ov`=0, `busy`=0 on the next cycle, and no `ov` afterwards. A reset coincident with `iv` leaves the block in IDLE.
- `bin`=0, `cin`=0x1234 -> `pout`=0x00001234. A second `iv` on the DONE cycle gives back-to-back `ov` pulses 17 cycles apart, each with the correct result.
